// File: rtl/snake_body_store.sv
// Snake body coordinate table: applies move/grow shifts, checks the new
// head against the body, streams the table and derives tail direction.
//
// Ports:
//   clock_25                   25 MHz clock
//   reset                      asynchronous active-low reset
//   move_req, grow             move command pulse and its grow qualifier
//   head_x/head_y              head before the move (becomes segment 0)
//   next_x/next_y              head after the move (collision probe)
//   busy, done, self_hit       shift status and collision result
//   snake_length               current segment count
//   body_count, snake_body_x/y round-robin table broadcast
//   up/down/left/right_tail    one-hot direction from tail toward L-2
module snake_body_store #(
    parameter int SNAKE_LENGTH_BIT = 7,
    parameter int SNAKE_LENGTH_MAX = 2 ** SNAKE_LENGTH_BIT,
    parameter int INIT_LENGTH      = 3,
    parameter int INIT_X           = 60,
    parameter int INIT_Y           = 40
) (
    input  logic                        clock_25,
    input  logic                        reset,
    input  logic                        move_req,
    input  logic                        grow,
    input  logic [6:0]                  head_x,
    input  logic [6:0]                  head_y,
    input  logic [6:0]                  next_x,
    input  logic [6:0]                  next_y,
    output logic                        busy,
    output logic                        done,
    output logic                        self_hit,
    output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
    output logic [SNAKE_LENGTH_BIT-1:0] body_count,
    output logic [6:0]                  snake_body_x,
    output logic [6:0]                  snake_body_y,
    output logic                        up_tail,
    output logic                        down_tail,
    output logic                        left_tail,
    output logic                        right_tail
);

    localparam int LB  = SNAKE_LENGTH_BIT;
    localparam int TBL = SNAKE_LENGTH_MAX - 1;

    localparam logic [LB-1:0] L_SAT   = LB'(SNAKE_LENGTH_MAX - 1);
    localparam logic [LB-1:0] BC_LAST = LB'(SNAKE_LENGTH_MAX - 2);
    localparam logic [LB-1:0] L_INIT  = LB'(INIT_LENGTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [6:0]    r_tab_x [TBL];
    logic [6:0]    r_tab_y [TBL];
    logic [LB-1:0] r_len;
    logic [LB-1:0] r_idx;
    logic          r_grow;
    logic          r_first;
    logic [6:0]    r_hx;
    logic [6:0]    r_hy;
    logic [6:0]    r_nx;
    logic [6:0]    r_ny;
    logic          r_hit;
    logic          r_busy;
    logic          r_done;
    logic          r_self_hit;
    logic [LB-1:0] r_bc;
    logic [6:0]    r_bx;
    logic [6:0]    r_by;
    logic          r_up;
    logic          r_dn;
    logic          r_lf;
    logic          r_rt;

    logic [LB-1:0] w_bc_next;
    logic [LB-1:0] w_prev_idx;
    logic [LB-1:0] w_tail_idx;
    logic [LB-1:0] w_pen_idx;
    logic [6:0]    w_tx;
    logic [6:0]    w_ty;
    logic [6:0]    w_px;
    logic [6:0]    w_py;
    logic          w_prev_hit;
    logic          w_tail_hit;
    logic          w_grow_ok;

    assign w_bc_next  = (r_bc == BC_LAST) ? '0 : r_bc + 1'b1;
    assign w_prev_idx = r_idx - 1'b1;
    assign w_tail_idx = r_len - 1'b1;
    assign w_pen_idx  = r_len - LB'(2);

    assign w_tx = r_tab_x[w_tail_idx];
    assign w_ty = r_tab_y[w_tail_idx];
    assign w_px = r_tab_x[w_pen_idx];
    assign w_py = r_tab_y[w_pen_idx];

    assign w_prev_hit = (r_tab_x[w_prev_idx] == r_nx) &&
                        (r_tab_y[w_prev_idx] == r_ny);
    assign w_tail_hit = (w_tx == r_nx) && (w_ty == r_ny);

    // A grow request at full length degrades to a plain move.
    assign w_grow_ok = grow && (r_len < L_SAT);

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_len      <= L_INIT;
            r_idx      <= '0;
            r_grow     <= 1'b0;
            r_first    <= 1'b0;
            r_hx       <= '0;
            r_hy       <= '0;
            r_nx       <= '0;
            r_ny       <= '0;
            r_hit      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_self_hit <= 1'b0;
            r_bc       <= '0;
            r_bx       <= 7'(INIT_X - 1);
            r_by       <= 7'(INIT_Y);
            r_up       <= 1'b0;
            r_dn       <= 1'b0;
            r_lf       <= 1'b0;
            r_rt       <= 1'b1;
            for (int i = 0; i < TBL; i++) begin
                if (i < INIT_LENGTH) begin
                    r_tab_x[i] <= 7'(INIT_X - 1 - i);
                    r_tab_y[i] <= 7'(INIT_Y);
                end else begin
                    r_tab_x[i] <= '0;
                    r_tab_y[i] <= '0;
                end
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // Broadcast only advances while the table is stable.
                    r_bc <= w_bc_next;
                    r_bx <= r_tab_x[w_bc_next];
                    r_by <= r_tab_y[w_bc_next];
                    if (move_req) begin
                        r_grow     <= w_grow_ok;
                        r_idx      <= w_grow_ok ? r_len : w_tail_idx;
                        r_hx       <= head_x;
                        r_hy       <= head_y;
                        r_nx       <= next_x;
                        r_ny       <= next_y;
                        r_hit      <= 1'b0;
                        r_first    <= 1'b1;
                        r_self_hit <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_first <= 1'b0;
                    if (r_idx != '0) begin
                        // Source entry is read before it is overwritten,
                        // so the compare sees the pre-move body.
                        r_hit <= r_hit | w_prev_hit |
                                 (r_first & r_grow & w_tail_hit);
                        r_tab_x[r_idx] <= r_tab_x[w_prev_idx];
                        r_tab_y[r_idx] <= r_tab_y[w_prev_idx];
                        r_idx          <= w_prev_idx;
                    end else begin
                        r_tab_x[0] <= r_hx;
                        r_tab_y[0] <= r_hy;
                        if (r_grow) begin
                            r_len <= r_len + 1'b1;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done     <= 1'b1;
                    r_self_hit <= r_hit;
                    r_busy     <= 1'b0;
                    // Coincident tail cells keep the previous direction.
                    if (w_px > w_tx) begin
                        {r_up, r_dn, r_lf, r_rt} <= 4'b0001;
                    end else if (w_px < w_tx) begin
                        {r_up, r_dn, r_lf, r_rt} <= 4'b0010;
                    end else if (w_py < w_ty) begin
                        {r_up, r_dn, r_lf, r_rt} <= 4'b1000;
                    end else if (w_py > w_ty) begin
                        {r_up, r_dn, r_lf, r_rt} <= 4'b0100;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign self_hit     = r_self_hit;
    assign snake_length = r_len;
    assign body_count   = r_bc;
    assign snake_body_x = r_bx;
    assign snake_body_y = r_by;
    assign up_tail      = r_up;
    assign down_tail    = r_dn;
    assign left_tail    = r_lf;
    assign right_tail   = r_rt;

endmodule

// File: tb/tb_snake_body_store.sv
// Scoreboard bench for snake_body_store: directed moves push expected
// done results; a monitor pops and compares on every done pulse.
module tb_snake_body_store;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       move_req;
    logic       grow;
    logic [6:0] head_x;
    logic [6:0] head_y;
    logic [6:0] next_x;
    logic [6:0] next_y;
    logic       busy;
    logic       done;
    logic       self_hit;
    logic [6:0] snake_length;
    logic [6:0] body_count;
    logic [6:0] snake_body_x;
    logic [6:0] snake_body_y;
    logic       up_tail;
    logic       down_tail;
    logic       left_tail;
    logic       right_tail;

    snake_body_store dut (
        .clock_25     (clk),
        .reset        (rst_n),
        .move_req     (move_req),
        .grow         (grow),
        .head_x       (head_x),
        .head_y       (head_y),
        .next_x       (next_x),
        .next_y       (next_y),
        .busy         (busy),
        .done         (done),
        .self_hit     (self_hit),
        .snake_length (snake_length),
        .body_count   (body_count),
        .snake_body_x (snake_body_x),
        .snake_body_y (snake_body_y),
        .up_tail      (up_tail),
        .down_tail    (down_tail),
        .left_tail    (left_tail),
        .right_tail   (right_tail)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic hit;
        int   len;
        int   cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   frozen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                m_e = sb_q.pop_front();
                chk("done_hit", int'(self_hit), int'(m_e.hit));
                chk("done_len", int'(snake_length), m_e.len);
                chk("done_cycle", cyc, m_e.cyc);
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sb_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_move(input logic [6:0] hx, input logic [6:0] hy,
                           input logic [6:0] nx, input logic [6:0] ny,
                           input logic g, input logic eh,
                           input int el, input int lat);
        int n = 0;
        wait_idle();
        move_req = 1'b1;
        grow     = g;
        head_x   = hx;
        head_y   = hy;
        next_x   = nx;
        next_y   = ny;
        sb_q.push_back('{hit: eh, len: el, cyc: cyc + 1 + lat});
        @(negedge clk);
        move_req = 1'b0;
        grow     = 1'b0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("done_timeout", 1, 0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic read_entry(input int k, input int ex, input int ey,
                              input string name);
        int n = 0;
        @(negedge clk);
        while (int'(body_count) != k && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idx"}, int'(body_count), k);
        chk({name, "_x"}, int'(snake_body_x), ex);
        chk({name, "_y"}, int'(snake_body_y), ey);
    endtask

    task automatic chk_flags(input string name, input logic [3:0] exp);
        chk(name, int'({up_tail, down_tail, left_tail, right_tail}),
            int'(exp));
    endtask

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        move_req = 1'b0;
        grow     = 1'b0;
        head_x   = '0;
        head_y   = '0;
        next_x   = '0;
        next_y   = '0;

        // T1: reset state and broadcast wrap
        @(negedge clk);
        apply_reset();
        #1;
        chk("rst_len", int'(snake_length), 3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_hit", int'(self_hit), 0);
        chk("rst_bc", int'(body_count), 0);
        chk("rst_bx", int'(snake_body_x), 59);
        chk("rst_by", int'(snake_body_y), 40);
        chk_flags("rst_flags", 4'b0001);
        read_entry(1, 58, 40, "t1_e1");
        read_entry(2, 57, 40, "t1_e2");
        read_entry(0, 59, 40, "t1_e0");
        n = 0;
        while (int'(body_count) != 126 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("bc_top", int'(body_count), 126);
        @(negedge clk);
        chk("bc_wrap", int'(body_count), 0);

        // T2: plain move
        do_move(60, 40, 61, 40, 1'b0, 1'b0, 3, 4);
        read_entry(0, 60, 40, "t2_e0");
        read_entry(1, 59, 40, "t2_e1");
        read_entry(2, 58, 40, "t2_e2");
        chk_flags("t2_flags", 4'b0001);

        // T3: grow from reset
        apply_reset();
        do_move(60, 40, 61, 40, 1'b1, 1'b0, 4, 5);
        read_entry(0, 60, 40, "t3_e0");
        read_entry(3, 57, 40, "t3_e3");
        chk_flags("t3_flags", 4'b0001);

        // T4: body hit, vacated tail, grown tail
        do_move(61, 40, 59, 40, 1'b0, 1'b1, 4, 5);
        do_move(62, 40, 58, 40, 1'b0, 1'b0, 4, 5);
        do_move(63, 40, 59, 40, 1'b1, 1'b1, 5, 6);
        repeat (3) @(negedge clk);
        chk("t4_hit_held", int'(self_hit), 1);
        read_entry(4, 59, 40, "t4_e4");

        // T5: move_req while busy is dropped; broadcast frozen
        wait_idle();
        move_req = 1'b1;
        head_x   = 64;
        head_y   = 40;
        next_x   = 65;
        next_y   = 40;
        sb_q.push_back('{hit: 1'b0, len: 5, cyc: cyc + 1 + 6});
        @(negedge clk);
        move_req = 1'b0;
        frozen   = int'(body_count);
        chk("t5_busy", int'(busy), 1);
        @(negedge clk);
        move_req = 1'b1;
        grow     = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        grow     = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            chk("t5_frozen", int'(body_count), frozen);
            @(negedge clk);
            n++;
        end
        chk("t5_done_seen", int'(done), 1);
        chk("t5_frozen_done", int'(body_count), frozen);
        @(negedge clk);
        chk("t5_resume", int'(body_count), frozen == 126 ? 0 : frozen + 1);
        repeat (20) @(negedge clk);
        chk("t5_len", int'(snake_length), 5);
        read_entry(0, 64, 40, "t5_e0");

        // Tail turning upward
        apply_reset();
        do_move(60, 40, 60, 39, 1'b0, 1'b0, 3, 4);
        do_move(60, 39, 60, 38, 1'b0, 1'b0, 3, 4);
        chk_flags("turn_right", 4'b0001);
        do_move(60, 38, 60, 37, 1'b0, 1'b0, 3, 4);
        chk_flags("turn_up", 4'b1000);
        do_move(60, 37, 59, 37, 1'b1, 1'b0, 4, 5);
        chk_flags("grow_up", 4'b1000);
        read_entry(3, 60, 40, "up_e3");

        // T6: reset mid-shift, then saturate length
        wait_idle();
        move_req = 1'b1;
        grow     = 1'b1;
        head_x   = 60;
        head_y   = 40;
        next_x   = 61;
        next_y   = 40;
        @(negedge clk);
        move_req = 1'b0;
        grow     = 1'b0;
        @(negedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        chk("t6_len", int'(snake_length), 3);
        chk("t6_busy", int'(busy), 0);
        chk("t6_bc", int'(body_count), 0);
        chk("t6_bx", int'(snake_body_x), 59);
        chk_flags("t6_flags", 4'b0001);
        @(negedge clk);
        sb_q.delete();
        rst_n = 1'b1;
        read_entry(0, 59, 40, "t6_e0");
        read_entry(3, 0, 0, "t6_e3");
        for (int l = 3; l < 127; l++) begin
            do_move(10, 10, 100, 100, 1'b1, 1'b0, l + 1, l + 2);
        end
        do_move(10, 10, 100, 100, 1'b1, 1'b0, 127, 128);
        chk("t6_sat_len", int'(snake_length), 127);
        read_entry(126, 58, 40, "t6_e126");

        repeat (5) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
